seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_UNITS = 2'd0,
    ST_GAP_U = 2'd1,
    ST_TENS  = 2'd2,
    ST_GAP_T = 2'd3
  } state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 is the rightmost entry, so GLYPHS[d] is the glyph for digit d.
  localparam logic [9:0][6:0] GLYPHS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; any code above 9 renders blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // NOTE: default assigned first so every path drives o_seg and no latch forms.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_digit <= 4'd9) begin
      o_seg = GLYPHS[i_digit];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed seven-segment driver with guard gaps and
// frame-aligned display updates from a 0..15 upstream value.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 8,
  parameter int BLANK_TENS  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] value_in,
  input  logic       value_valid,
  output logic       value_ack,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOAD_DIGIT = CNT_W'(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LOAD_GAP   = CNT_W'(GUARD_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic [3:0] r_disp;
  logic [3:0] r_pending;
  logic       r_new;
  logic [3:0] w_disp_next;
  logic       w_ack_next;
  logic       w_boundary;

  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic       w_tens_blank;
  logic [3:0] w_digit;
  logic [1:0] w_an_next;
  logic [6:0] w_seg_next;

  // The counter holds the cycles left in the current state; at 1 we move on.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (enable) begin
      if (r_cnt == CNT_LAST) begin
        case (r_state)
          ST_UNITS: begin w_state_next = ST_GAP_U; w_cnt_next = LOAD_GAP;   end
          ST_GAP_U: begin w_state_next = ST_TENS;  w_cnt_next = LOAD_DIGIT; end
          ST_TENS:  begin w_state_next = ST_GAP_T; w_cnt_next = LOAD_GAP;   end
          default:  begin w_state_next = ST_UNITS; w_cnt_next = LOAD_DIGIT; end
        endcase
      end else begin
        w_cnt_next = r_cnt - CNT_LAST;
      end
    end
  end

  assign w_boundary = enable && (r_state == ST_GAP_T) && (r_cnt == CNT_LAST);

  // A value arriving on the boundary edge itself bypasses the pending register.
  always_comb begin
    w_disp_next = r_disp;
    w_ack_next  = 1'b0;
    if (w_boundary) begin
      if (value_valid) begin
        w_disp_next = value_in;
        w_ack_next  = 1'b1;
      end else if (r_new) begin
        w_disp_next = r_pending;
        w_ack_next  = 1'b1;
      end
    end
  end

  assign w_tens       = (w_disp_next >= 4'd10) ? 4'd1 : 4'd0;
  assign w_units      = (w_disp_next >= 4'd10) ? (w_disp_next - 4'd10) : w_disp_next;
  assign w_tens_blank = (BLANK_TENS != 0) && (w_tens == 4'd0);

  // Outputs are derived from next-state values so the registered outputs
  // change on the same edge as the state they depict. Code 4'hF decodes blank.
  always_comb begin
    w_digit   = 4'hF;
    w_an_next = 2'b11;
    if (enable) begin
      case (w_state_next)
        ST_UNITS: begin
          w_digit   = w_units;
          w_an_next = 2'b10;
        end
        ST_TENS: begin
          if (!w_tens_blank) begin
            w_digit   = w_tens;
            w_an_next = 2'b01;
          end
        end
        default: begin
          w_digit   = 4'hF;
          w_an_next = 2'b11;
        end
      endcase
    end
  end

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_seg_next)
  );

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_GAP_T;
      r_cnt     <= CNT_LAST;
      r_disp    <= 4'd0;
      r_pending <= 4'd0;
      r_new     <= 1'b0;
      value_ack <= 1'b0;
      seg       <= SEG_BLANK;
      an        <= 2'b11;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_disp    <= w_disp_next;
      value_ack <= w_ack_next;
      seg       <= w_seg_next;
      an        <= w_an_next;
      if (value_valid) begin
        r_pending <= value_in;
      end
      if (w_boundary) begin
        r_new <= 1'b0;
      end else if (value_valid) begin
        r_new <= 1'b1;
      end
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 10-cycle frame (4+1+4+1).
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] BL = 7'h7F;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] value_in;
  logic       value_valid;
  logic       value_ack;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       en;
    logic       vld;
    logic [3:0] val;
    logic [1:0] an;
    logic [6:0] seg;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  seg7_scan_driver #(
    .REFRESH_DIV (4),
    .GUARD_CYC   (1),
    .BLANK_TENS  (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ack   (value_ack),
    .seg         (seg),
    .an          (an),
    .dp          (dp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] e_an,
                           input logic [6:0] e_seg, input logic e_ack);
    check({tag, " an"},  {6'd0, an},  {6'd0, e_an});
    check({tag, " seg"}, {1'b0, seg}, {1'b0, e_seg});
    check({tag, " ack"}, {7'd0, value_ack}, {7'd0, e_ack});
  endtask

  // One 10-cycle frame: rows 0-3 UNITS, 4 GAP_U, 5-8 TENS, 9 GAP_T.
  // Optional valid inputs on row 0 (boundary edge), row 2 and row 7.
  task automatic add_frame(input logic ack, input logic [6:0] u_seg,
                           input logic [1:0] t_an, input logic [6:0] t_seg,
                           input logic b_vld, input logic [3:0] b_val,
                           input logic m1_vld, input logic [3:0] m1_val,
                           input logic m2_vld, input logic [3:0] m2_val);
    vec_t v;
    for (int i = 0; i < 10; i++) begin
      v.en  = 1'b1;
      v.vld = 1'b0;
      v.val = 4'd0;
      if (i == 0 && b_vld)  begin v.vld = 1'b1; v.val = b_val;  end
      if (i == 2 && m1_vld) begin v.vld = 1'b1; v.val = m1_val; end
      if (i == 7 && m2_vld) begin v.vld = 1'b1; v.val = m2_val; end
      if (i < 4) begin
        v.an = 2'b10; v.seg = u_seg;
      end else if (i >= 5 && i <= 8) begin
        v.an = t_an;  v.seg = t_seg;
      end else begin
        v.an = 2'b11; v.seg = BL;
      end
      v.ack = (i == 0) ? ack : 1'b0;
      vecs.push_back(v);
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    value_in    = 4'd0;
    value_valid = 1'b0;

    // Reset state.
    tick();
    check_out("reset", 2'b11, BL, 1'b0);
    check("reset dp", {7'd0, dp}, 8'd1);
    tick();
    reset = 1'b0;

    // A: display 0, tens blank; 13 arrives mid-frame.
    add_frame(1'b0, G0, 2'b11, BL, 1'b0, 4'd0, 1'b1, 4'd13, 1'b0, 4'd0);
    // B: 13 shown with ack; 5 then 14 arrive in this frame.
    add_frame(1'b1, G3, 2'b01, G1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 4'd14);
    // C: latest (14) wins, single ack.
    add_frame(1'b1, G4, 2'b01, G1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    // D: nothing new, display holds, no ack.
    add_frame(1'b0, G4, 2'b01, G1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    // E: 9 valid exactly on the boundary edge goes straight to display.
    add_frame(1'b1, G9, 2'b11, BL, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0);
    // F: 9 held, no ack.
    add_frame(1'b0, G9, 2'b11, BL, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      enable      = vecs[i].en;
      value_valid = vecs[i].vld;
      value_in    = vecs[i].val;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].ack);
    end
    value_valid = 1'b0;

    // Enable dropped for 7 cycles in TENS; frame stretches by exactly 7.
    value_valid = 1'b1;
    value_in    = 4'd12;
    tick();
    check_out("pause b0", 2'b10, G2, 1'b1);
    value_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_out($sformatf("pause u%0d", i), 2'b10, G2, 1'b0);
    end
    tick();
    check_out("pause gapu", 2'b11, BL, 1'b0);
    tick();
    check_out("pause t0", 2'b01, G1, 1'b0);
    tick();
    check_out("pause t1", 2'b01, G1, 1'b0);
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      value_valid = (k == 3);
      value_in    = (k == 3) ? 4'd7 : 4'd0;
      tick();
      check_out($sformatf("pause off%0d", k), 2'b11, BL, 1'b0);
    end
    value_valid = 1'b0;
    enable      = 1'b1;
    tick();
    check_out("pause t2", 2'b01, G1, 1'b0);
    tick();
    check_out("pause t3", 2'b01, G1, 1'b0);
    tick();
    check_out("pause gapt", 2'b11, BL, 1'b0);
    tick();
    check_out("pause next", 2'b10, G7, 1'b1);

    // Mid-frame reset with 15 pending: async blank, pending discarded.
    value_valid = 1'b1;
    value_in    = 4'd15;
    tick();
    check_out("rst pre", 2'b10, G7, 1'b0);
    value_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("rst async", 2'b11, BL, 1'b0);
    check("rst async dp", {7'd0, dp}, 8'd1);
    tick();
    check_out("rst hold", 2'b11, BL, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i < 4 || i == 10) begin
        check_out($sformatf("post%0d", i), 2'b10, G0, 1'b0);
      end else begin
        check_out($sformatf("post%0d", i), 2'b11, BL, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
